// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-source register-file writeback arbiter with per-source FIFO queues
//
// wb_arbiter_queue : one source's writeback FIFO (DEPTH entries of addr/data)
//   clk, rst              clock, synchronous active-low reset
//   push_valid/ready      beat handshake; push_addr/push_data sampled on acceptance
//   pop                   dequeue the head this edge (only asserted while head_valid)
//   head_valid/addr/data  oldest queued entry
//   busy                  one bit per destination register held by a valid entry
//
// wb_arbiter : top level
//   clk, rst                          clock, synchronous active-low reset (0 = reset)
//   a_valid/a_ready/a_addr/a_data     source A (ALU pipe) writeback beats
//   b_valid/b_ready/b_addr/b_data     source B (LSU/MDU) writeback beats
//   we/waddr/wdata                    registered regfile write port
//   busy                              registers targeted by any queued or pending write

module wb_arbiter_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_valid,
    output logic        push_ready,
    input  logic [4:0]  push_addr,
    input  logic [63:0] push_data,
    input  logic        pop,
    output logic        head_valid,
    output logic [4:0]  head_addr,
    output logic [63:0] head_data,
    output logic [31:0] busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]    addr_mem [DEPTH];
    logic [63:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] offs;
    logic          push;

    // Ready looks only at the current count, so a full queue refuses a beat
    // even when its head is being granted on the same edge.
    assign push_ready = rst && (count < CW'(DEPTH));

    // Register 0 writes are acknowledged but dropped.
    assign push       = push_valid && push_ready && (push_addr != 5'd0);
    assign head_valid = (count != '0);
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only observed through count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        busy = '0;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ({1'b0, offs} < count) busy[addr_mem[i]] = 1'b1;
        end
    end
endmodule

module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [63:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [63:0] b_data,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [63:0] wdata,
    output logic [31:0] busy
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          a_head_valid;
    logic [4:0]    a_head_addr;
    logic [63:0]   a_head_data;
    logic [31:0]   a_busy;
    logic          b_head_valid;
    logic [4:0]    b_head_addr;
    logic [63:0]   b_head_data;
    logic [31:0]   b_busy;
    logic          grant_a;
    logic          grant_b;
    logic [SW-1:0] starve;
    logic [31:0]   we_onehot;

    wb_arbiter_queue #(.DEPTH(DEPTH)) u_queue_a (
        .clk        (clk),
        .rst        (rst),
        .push_valid (a_valid),
        .push_ready (a_ready),
        .push_addr  (a_addr),
        .push_data  (a_data),
        .pop        (grant_a),
        .head_valid (a_head_valid),
        .head_addr  (a_head_addr),
        .head_data  (a_head_data),
        .busy       (a_busy)
    );

    wb_arbiter_queue #(.DEPTH(DEPTH)) u_queue_b (
        .clk        (clk),
        .rst        (rst),
        .push_valid (b_valid),
        .push_ready (b_ready),
        .push_addr  (b_addr),
        .push_data  (b_data),
        .pop        (grant_b),
        .head_valid (b_head_valid),
        .head_addr  (b_head_addr),
        .head_data  (b_head_data),
        .busy       (b_busy)
    );

    // A normally wins; B wins when alone or once it has lost STARVE_LIMIT times in a row.
    assign grant_b = b_head_valid && (!a_head_valid || (starve == SW'(STARVE_LIMIT)));
    assign grant_a = a_head_valid && !grant_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve <= '0;
        end else if (!b_head_valid || grant_b) begin
            starve <= '0;
        end else if (grant_a && (starve != SW'(STARVE_LIMIT))) begin
            starve <= starve + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= grant_a || grant_b;
            if (grant_a) begin
                waddr <= a_head_addr;
                wdata <= a_head_data;
            end else if (grant_b) begin
                waddr <= b_head_addr;
                wdata <= b_head_data;
            end
        end
    end

    assign we_onehot = we ? (32'd1 << waddr) : 32'd0;
    assign busy      = rst ? ((a_busy | b_busy | we_onehot) & ~32'd1) : 32'd0;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter with a queue-based reference model
module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_addr = '0;
    logic [63:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = '0;
    logic [63:0] b_data = '0;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [31:0] busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy)
    );

    // Reference model: each source is a plain queue of {addr, data}.
    logic [68:0] mqa [$];
    logic [68:0] mqb [$];
    int          m_starve = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [63:0] m_wdata = '0;

    task automatic model_edge();
        bit acc_a, acc_b, had_b, ga, gb;
        if (!rst) begin
            mqa.delete();
            mqb.delete();
            m_starve = 0;
            m_we = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            acc_a = a_valid && (mqa.size() < DEPTH);
            acc_b = b_valid && (mqb.size() < DEPTH);
            had_b = (mqb.size() > 0);
            gb = had_b && ((mqa.size() == 0) || (m_starve == LIMIT));
            ga = !gb && (mqa.size() > 0);
            m_we = ga || gb;
            if (ga) {m_waddr, m_wdata} = mqa.pop_front();
            else if (gb) {m_waddr, m_wdata} = mqb.pop_front();
            if (!had_b || gb) m_starve = 0;
            else if (ga && m_starve < LIMIT) m_starve = m_starve + 1;
            if (acc_a && a_addr != 5'd0) mqa.push_back({a_addr, a_data});
            if (acc_b && b_addr != 5'd0) mqb.push_back({b_addr, b_data});
        end
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] r = '0;
        if (rst) begin
            foreach (mqa[i]) r[mqa[i][68:64]] = 1'b1;
            foreach (mqb[i]) r[mqb[i][68:64]] = 1'b1;
            if (m_we) r[m_waddr] = 1'b1;
            r[0] = 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_addr = '0;
        b_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h33;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 64'h44;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready actual=%b%b expected=00", a_ready, b_ready);
        end
        repeat (3) tick();
        checks++;
        if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_out actual=%b/%0d/%0h expected=0/0/0", we, waddr, wdata);
        end
        checks++;
        if (busy !== 32'd0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy actual=%0h/%b%b expected=0/00", busy, a_ready, b_ready);
        end
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready actual=%b%b expected=11", a_ready, b_ready);
        end
        tick();
        checks++;
        if (we !== 1'b0 || busy !== 32'd0) begin
            failures++;
            $display("FAIL reset_no_stale actual=%b/%0h expected=0/0", we, busy);
        end
    endtask

    task automatic test_single_beat();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h1234;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready actual=%b expected=1", a_ready);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (we !== 1'b0 || busy !== 32'h20) begin
            failures++;
            $display("FAIL single_queued actual=%b/%0h expected=0/20", we, busy);
        end
        tick();
        checks++;
        if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 64'h1234 || busy !== 32'h20) begin
            failures++;
            $display("FAIL single_write actual=%b/%0d/%0h/%0h expected=1/5/1234/20", we, waddr, wdata, busy);
        end
        tick();
        checks++;
        if (we !== 1'b0 || busy !== 32'd0 || waddr !== 5'd5 || wdata !== 64'h1234) begin
            failures++;
            $display("FAIL single_after actual=%b/%0h/%0d/%0h expected=0/0/5/1234", we, busy, waddr, wdata);
        end
    endtask

    task automatic test_zero_addr();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 64'hFFFF;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_ready actual=%b expected=1", a_ready);
        end
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (we !== 1'b0 || busy !== 32'd0) begin
                failures++;
                $display("FAIL zero_discard cycle=%0d actual=%b/%0h expected=0/0", k, we, busy);
            end
            tick();
        end
    endtask

    // Both sources stream continuously: writes must follow A,A,A,A,B, each source in order,
    // and A's queue must be full right after every B grant.
    task automatic test_starvation();
        int sa = 0, sb = 0, ea = 0, eb = 0, nw = 0;
        bit acc_a, acc_b, src, exp_src;
        for (int cyc = 0; cyc < 300 && nw < 25; cyc++) begin
            a_valid = 1'b1; a_addr = 5'(1 + sa % 15); a_data = {1'b0, 63'(sa)};
            b_valid = 1'b1; b_addr = 5'(16 + sb % 16); b_data = {1'b1, 63'(sb)};
            #1;
            acc_a = a_ready;
            acc_b = b_ready;
            tick();
            if (acc_a) sa++;
            if (acc_b) sb++;
            if (we === 1'b1) begin
                src = wdata[63];
                exp_src = (nw % 5 == 4);
                checks++;
                if (src !== exp_src) begin
                    failures++;
                    $display("FAIL starve_pattern write=%0d actual=%0d expected=%0d", nw, src, exp_src);
                end
                checks++;
                if (!src && wdata[62:0] !== 63'(ea)) begin
                    failures++;
                    $display("FAIL order_a actual=%0d expected=%0d", wdata[62:0], ea);
                end else if (src && wdata[62:0] !== 63'(eb)) begin
                    failures++;
                    $display("FAIL order_b actual=%0d expected=%0d", wdata[62:0], eb);
                end
                if (src) begin
                    eb++;
                    checks++;
                    if (a_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL full_backpressure actual=%b expected=0", a_ready);
                    end
                end else begin
                    ea++;
                end
                nw++;
            end
        end
        checks++;
        if (nw < 25) begin
            failures++;
            $display("FAIL starve_timeout actual=%0d expected=25", nw);
        end
        idle_inputs();
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 64'h77;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 64'h99;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0 || busy !== 32'd0) begin
            failures++;
            $display("FAIL midreset_during actual=%b%b/%0h expected=00/0", a_ready, b_ready, busy);
        end
        tick();
        checks++;
        if (we !== 1'b0 || busy !== 32'd0) begin
            failures++;
            $display("FAIL midreset_out actual=%b/%0h expected=0/0", we, busy);
        end
        rst = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_release actual=%b%b expected=11", a_ready, b_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (we !== 1'b0 || busy !== 32'd0) begin
                failures++;
                $display("FAIL midreset_stale cycle=%0d actual=%b/%0h expected=0/0", k, we, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 11; k++) begin
            a_valid = 1'b1; a_addr = 5'(1 + k % 7); a_data = 64'hA000 + 64'(k);
            #1;
            checks++;
            if (a_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready beat=%0d actual=%b expected=1", k, a_ready);
            end
            tick();
            if (k >= 1) begin
                checks++;
                if (we !== 1'b1 || waddr !== 5'(1 + (k - 1) % 7) || wdata !== 64'hA000 + 64'(k - 1)) begin
                    failures++;
                    $display("FAIL b2b_order beat=%0d actual=%b/%0d/%0h expected=1/%0d/%0h",
                             k - 1, we, waddr, wdata, 1 + (k - 1) % 7, 64'hA000 + 64'(k - 1));
                end
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (we !== 1'b1 || wdata !== 64'hA00A) begin
            failures++;
            $display("FAIL b2b_last actual=%b/%0h expected=1/a00a", we, wdata);
        end
        tick();
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain actual=%b expected=0", we);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom_range(0, 99) != 0);
            a_valid = ($urandom_range(0, 9) < 7);
            a_addr = 5'($urandom_range(0, 31));
            a_data = {$urandom, $urandom};
            b_valid = ($urandom_range(0, 9) < 5);
            b_addr = 5'($urandom_range(0, 31));
            b_data = {$urandom, $urandom};
            #1;
            checks++;
            if (a_ready !== (rst && mqa.size() < DEPTH) || b_ready !== (rst && mqb.size() < DEPTH)) begin
                failures++;
                $display("FAIL rand_ready cycle=%0d actual=%b%b expected=%b%b", cyc, a_ready, b_ready,
                         rst && mqa.size() < DEPTH, rst && mqb.size() < DEPTH);
            end
            checks++;
            if (busy !== m_busy()) begin
                failures++;
                $display("FAIL rand_busy cycle=%0d actual=%0h expected=%0h", cyc, busy, m_busy());
            end
            tick();
            checks++;
            if (we !== m_we || waddr !== m_waddr || wdata !== m_wdata) begin
                failures++;
                $display("FAIL rand_write cycle=%0d actual=%b/%0d/%0h expected=%b/%0d/%0h",
                         cyc, we, waddr, wdata, m_we, m_waddr, m_wdata);
            end
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_zero_addr();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
